// File: rtl/eth_speed_detect_pkg.sv
// Shared speed/class encodings for the Ethernet link speed detector.
package eth_speed_detect_pkg;

  typedef enum logic [1:0] {
    SPEED_10M   = 2'b00,
    SPEED_100M  = 2'b01,
    SPEED_1000M = 2'b10
  } speed_e;

  // MII (4-bit, SDR) framing applies to both 10M and 100M.
  function automatic logic is_mii(speed_e s);
    return s != SPEED_1000M;
  endfunction

endpackage

// File: rtl/eth_speed_detect_if.sv
// Per-channel prescaled rx clocks in, committed speed/link status out.
interface eth_speed_detect_if #(
  parameter int CHANNELS = 1
);
  logic [CHANNELS-1:0]   prescale_in;
  logic [2*CHANNELS-1:0] speed;
  logic [CHANNELS-1:0]   mii_select;
  logic [CHANNELS-1:0]   link_up;
  logic [CHANNELS-1:0]   speed_change;

  modport master (
    output prescale_in,
    input  speed, mii_select, link_up, speed_change
  );

  modport slave (
    input  prescale_in,
    output speed, mii_select, link_up, speed_change
  );
endinterface

// File: rtl/eth_speed_detect_chan.sv
// Single-channel speed classifier: synchronizer, window counters,
// commit hysteresis and link-loss detection.
module eth_speed_detect_chan
  import eth_speed_detect_pkg::*;
#(
  parameter int REF_WIDTH    = 7,
  parameter int EDGE_WIDTH   = 2,
  parameter int THRESH_100M  = 32,
  parameter int STABLE_COUNT = 2,
  parameter int LOSS_WINDOWS = 4,
  parameter int SYNC_STAGES  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prescale_in,
  output logic [1:0] speed,
  output logic       mii_select,
  output logic       link_up,
  output logic       speed_change
);

  localparam int STAB_W = $clog2(STABLE_COUNT + 1);
  localparam int IDLE_W = $clog2(LOSS_WINDOWS + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [REF_WIDTH-1:0]   ref_count, ref_next;
  logic [EDGE_WIDTH-1:0]  edge_count, edge_next;
  logic [IDLE_W-1:0]      idle_cnt, idle_next;
  logic [STAB_W-1:0]      stable_cnt, stable_next;
  speed_e                 cand, cand_next, cls, speed_q;
  logic                   edge_seen, fast_close, slow_close;
  logic                   cls_valid, commit, loss;

  assign edge_seen = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];

  always_comb begin
    fast_close  = &edge_count;
    slow_close  = (&ref_count) & ~fast_close;
    cls_valid   = 1'b0;
    cls         = SPEED_1000M;
    loss        = 1'b0;
    ref_next    = ref_count + 1'b1;
    edge_next   = edge_count + EDGE_WIDTH'(edge_seen);
    idle_next   = idle_cnt;
    cand_next   = cand;
    stable_next = stable_cnt;

    // Fast close takes priority; any edge arriving in a closing cycle is dropped.
    if (fast_close) begin
      cls_valid = 1'b1;
      cls       = (ref_count >= REF_WIDTH'(THRESH_100M)) ? SPEED_100M : SPEED_1000M;
      ref_next  = '0;
      edge_next = '0;
      idle_next = '0;
    end else if (slow_close) begin
      ref_next  = '0;
      edge_next = '0;
      if (edge_count != '0) begin
        cls_valid = 1'b1;
        cls       = SPEED_10M;
        idle_next = '0;
      end else begin
        if (idle_cnt != IDLE_W'(LOSS_WINDOWS)) idle_next = idle_cnt + 1'b1;
        loss = (idle_next == IDLE_W'(LOSS_WINDOWS));
      end
    end

    if (cls_valid) begin
      if (cls == cand) begin
        if (stable_cnt != STAB_W'(STABLE_COUNT)) stable_next = stable_cnt + 1'b1;
      end else begin
        cand_next   = cls;
        stable_next = STAB_W'(1);
      end
    end
    commit = cls_valid && (stable_next == STAB_W'(STABLE_COUNT));
    if (loss) stable_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      ref_count    <= '0;
      edge_count   <= '0;
      idle_cnt     <= '0;
      stable_cnt   <= '0;
      cand         <= SPEED_1000M;
      speed_q      <= SPEED_1000M;
      mii_select   <= 1'b0;
      link_up      <= 1'b0;
      speed_change <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], prescale_in};
      ref_count    <= ref_next;
      edge_count   <= edge_next;
      idle_cnt     <= idle_next;
      stable_cnt   <= stable_next;
      cand         <= cand_next;
      speed_change <= commit && ((cls != speed_q) || !link_up);
      if (commit) begin
        speed_q    <= cls;
        mii_select <= is_mii(cls);
        link_up    <= 1'b1;
      end else if (loss) begin
        link_up    <= 1'b0;
      end
    end
  end

  assign speed = speed_q;

endmodule

// File: rtl/eth_speed_detect.sv
// Multi-channel Ethernet link speed detector: one independent classifier
// per monitored rx clock, outputs packed onto the status interface.
module eth_speed_detect
  import eth_speed_detect_pkg::*;
#(
  parameter int CHANNELS     = 1,
  parameter int REF_WIDTH    = 7,
  parameter int EDGE_WIDTH   = 2,
  parameter int THRESH_100M  = 32,
  parameter int STABLE_COUNT = 2,
  parameter int LOSS_WINDOWS = 4,
  parameter int SYNC_STAGES  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  eth_speed_detect_if.slave  bus
);

  if (THRESH_100M >= (1 << REF_WIDTH)) begin : g_bad_thresh
    $error("THRESH_100M must be below 2**REF_WIDTH");
  end
  if (SYNC_STAGES < 3) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 3");
  end

  // Reset asserts asynchronously but releases on a clk edge.
  logic [1:0] rst_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= '0;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_int_n = rst_q[1];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    eth_speed_detect_chan #(
      .REF_WIDTH    (REF_WIDTH),
      .EDGE_WIDTH   (EDGE_WIDTH),
      .THRESH_100M  (THRESH_100M),
      .STABLE_COUNT (STABLE_COUNT),
      .LOSS_WINDOWS (LOSS_WINDOWS),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_int_n),
      .prescale_in  (bus.prescale_in[i]),
      .speed        (bus.speed[2*i +: 2]),
      .mii_select   (bus.mii_select[i]),
      .link_up      (bus.link_up[i]),
      .speed_change (bus.speed_change[i])
    );
  end

endmodule

// File: tb/tb_eth_speed_detect.sv
// Directed bench for eth_speed_detect with a per-cycle window/hysteresis model.
module tb_eth_speed_detect;
  localparam int CH = 2;
  localparam int RW = 7;
  localparam int EW = 2;
  localparam int TH = 32;
  localparam int SC = 2;
  localparam int LW = 4;
  localparam int SS = 3;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  eth_speed_detect_if #(.CHANNELS(CH)) bus();

  eth_speed_detect #(
    .CHANNELS     (CH),
    .REF_WIDTH    (RW),
    .EDGE_WIDTH   (EW),
    .THRESH_100M  (TH),
    .STABLE_COUNT (SC),
    .LOSS_WINDOWS (LW),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Toggle generators: period[c] clk cycles between toggles, 0 = stopped.
  int period[CH];
  int tcnt[CH];
  initial begin
    bus.prescale_in = '0;
    for (int c = 0; c < CH; c++) begin period[c] = 0; tcnt[c] = 0; end
    forever begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        tcnt[c]++;
        if (period[c] != 0 && tcnt[c] >= period[c]) begin
          bus.prescale_in[c] = ~bus.prescale_in[c];
          tcnt[c] = 0;
        end
      end
    end
  end

  // Reference model: window accounting with integer counters.
  int         rel_cnt;
  int         m_hist[CH][SS];
  int         m_ref[CH], m_edg[CH], m_idle[CH], m_cand[CH], m_run[CH];
  logic [1:0] m_speed[CH];
  bit         m_link[CH], m_chg[CH];

  always @(posedge clk or negedge rst_n) begin
    int  ev, cls;
    bit  got;
    if (!rst_n) begin
      rel_cnt = 0;
      for (int c = 0; c < CH; c++) begin
        m_ref[c] = 0; m_edg[c] = 0; m_idle[c] = 0; m_cand[c] = 2; m_run[c] = 0;
        m_speed[c] = 2'b10; m_link[c] = 0; m_chg[c] = 0;
        for (int k = 0; k < SS; k++) m_hist[c][k] = 0;
      end
    end else if (rel_cnt < 2) begin
      rel_cnt++;
    end else begin
      for (int c = 0; c < CH; c++) begin
        ev  = m_hist[c][SS-1] ^ m_hist[c][SS-2];
        got = 0;
        cls = 0;
        m_chg[c] = 0;
        if (m_edg[c] == (1 << EW) - 1) begin
          got = 1;
          cls = (m_ref[c] >= TH) ? 1 : 2;
          m_ref[c] = 0; m_edg[c] = 0; m_idle[c] = 0;
        end else if (m_ref[c] == (1 << RW) - 1) begin
          if (m_edg[c] != 0) begin
            got = 1; cls = 0; m_idle[c] = 0;
          end else begin
            m_idle[c] = (m_idle[c] + 1 > LW) ? LW : m_idle[c] + 1;
            if (m_idle[c] == LW) begin m_link[c] = 0; m_run[c] = 0; end
          end
          m_ref[c] = 0; m_edg[c] = 0;
        end else begin
          m_ref[c]++;
          m_edg[c] += ev;
        end
        if (got) begin
          if (cls == m_cand[c]) m_run[c] = (m_run[c] + 1 > SC) ? SC : m_run[c] + 1;
          else begin m_cand[c] = cls; m_run[c] = 1; end
          if (m_run[c] == SC) begin
            m_chg[c]   = (cls != int'(m_speed[c])) || !m_link[c];
            m_speed[c] = 2'(cls);
            m_link[c]  = 1;
          end
        end
        for (int k = SS - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = int'(bus.prescale_in[c]);
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    logic [4:0] act, exp_v;
    forever begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        act   = {bus.speed[2*c +: 2], bus.mii_select[c], bus.link_up[c], bus.speed_change[c]};
        exp_v = {m_speed[c], m_speed[c] != 2'b10, m_link[c], m_chg[c]};
        n_checks++;
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL model_ch%0d t=%0t: {speed,mii,link,chg} actual=%b required=%b",
                   c, $time, act, exp_v);
        end
      end
    end
  end

  // Pulse counting and link-drop monitoring.
  int pulses[CH];
  bit dropped[CH];
  initial begin
    for (int c = 0; c < CH; c++) begin pulses[c] = 0; dropped[c] = 0; end
    forever begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (bus.speed_change[c]) pulses[c]++;
        if (!bus.link_up[c]) dropped[c] = 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_link(input int c, input logic val, input int budget, output int cycles);
    cycles = 0;
    while (bus.link_up[c] !== val && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    int cyc, p0, p1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_speed", int'(bus.speed), 4'b1010);
    check("reset_mii", int'(bus.mii_select), 0);
    check("reset_link", int'(bus.link_up), 0);
    check("reset_chg", int'(bus.speed_change), 0);
    rst_n = 1'b1;

    // ch0 at 1000M, ch1 at 100M
    period[0] = 4;
    period[1] = 20;
    wait_link(0, 1'b1, 200, cyc);
    check("lock_1000m_link", int'(bus.link_up[0]), 1);
    check("lock_1000m_speed", int'(bus.speed[1:0]), 2);
    check("lock_1000m_mii", int'(bus.mii_select[0]), 0);
    wait_link(1, 1'b1, 400, cyc);
    check("lock_100m_link", int'(bus.link_up[1]), 1);
    check("lock_100m_speed", int'(bus.speed[3:2]), 1);
    check("lock_100m_mii", int'(bus.mii_select[1]), 1);
    repeat (300) @(negedge clk);
    check("multi_speed", int'(bus.speed), 4'b0110);
    check("pulses_ch0", pulses[0], 1);
    check("pulses_ch1", pulses[1], 1);

    // One slow window on ch0 must not commit
    p0 = pulses[0];
    dropped[0] = 0;
    period[0] = 0;
    repeat (40) @(negedge clk);
    period[0] = 4;
    repeat (200) @(negedge clk);
    check("glitch_speed", int'(bus.speed[1:0]), 2);
    check("glitch_pulses", pulses[0], p0);
    check("glitch_link_held", int'(dropped[0]), 0);

    // Link loss on ch0
    period[0] = 0;
    wait_link(0, 1'b0, 900, cyc);
    check("loss_link", int'(bus.link_up[0]), 0);
    check("loss_not_early", int'(cyc >= 512), 1);
    check("loss_speed_hold", int'(bus.speed[1:0]), 2);
    check("loss_no_pulse", pulses[0], p0);

    // Relock ch0 at 100M
    period[0] = 20;
    wait_link(0, 1'b1, 400, cyc);
    check("relock_link", int'(bus.link_up[0]), 1);
    check("relock_speed", int'(bus.speed[1:0]), 1);
    check("relock_pulse", pulses[0], p0 + 1);

    // ch1 to 10M; empty windows interleave without dropping link
    p1 = pulses[1];
    dropped[1] = 0;
    period[1] = 200;
    repeat (1500) @(negedge clk);
    check("10m_speed", int'(bus.speed[3:2]), 0);
    check("10m_mii", int'(bus.mii_select[1]), 1);
    check("10m_link_held", int'(dropped[1]), 0);
    check("10m_pulse", pulses[1], p1 + 1);

    // Mid-window reset with both channels active
    period[0] = 4;
    period[1] = 20;
    repeat (600) @(negedge clk);
    check("pre_reset_speed", int'(bus.speed), 4'b0110);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_speed", int'(bus.speed), 4'b1010);
    check("async_rst_mii", int'(bus.mii_select), 0);
    check("async_rst_link", int'(bus.link_up), 0);
    check("async_rst_chg", int'(bus.speed_change), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_link(0, 1'b1, 200, cyc);
    wait_link(1, 1'b1, 400, cyc);
    check("post_rst_link", int'(bus.link_up), 2'b11);
    check("post_rst_speed", int'(bus.speed), 4'b0110);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
